// File: rtl/main_counter_pkg.sv
// rtl/main_counter_pkg.sv - shared types and default parameters for the counter game core
//
// Purpose : mode and result encodings plus default sizing for main_counter
//           and its event tallies.
// Contents: ctrl_e   - counting mode carried on the control input
//           who_e    - game result code carried on the who output
//           N_DEF, WIN_LIMIT_DEF, T_DEF - default widths and game length
package main_counter_pkg;

  localparam int N_DEF         = 4;
  localparam int WIN_LIMIT_DEF = 15;
  localparam int T_DEF         = 4;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    LOSE = 2'b01,
    WIN  = 2'b10
  } who_e;

endpackage

// File: rtl/main_counter_event_tally.sv
// rtl/main_counter_event_tally.sv - T-bit event tally with clear and limit look-ahead
//
// Purpose : counts events of one kind (winner or loser) for the current game.
// Ports   : clk      in  1  rising-edge clock
//           rst      in  1  synchronous reset, active-high
//           clr      in  1  clear to zero (game ended); wins over inc
//           inc      in  1  count one event
//           cnt      out T  current tally
//           hit_next out 1  tally sits at LIMIT-1: the next event ends the game
module event_tally
  import main_counter_pkg::*;
#(
  parameter int T     = T_DEF,
  parameter int LIMIT = WIN_LIMIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [T-1:0] cnt,
  output logic         hit_next
);

  logic [T-1:0] cnt_q;
  logic [T-1:0] cnt_d;

  // Clearing takes priority: the event that ends the game must not leave a
  // residual count behind, which is also why the tally never needs to saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + T'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign hit_next = (cnt_q == T'(LIMIT - 1));

endmodule

// File: rtl/main_counter.sv
// rtl/main_counter.sv - multimode counter game core with win/lose tallies
//
// Purpose : N-bit counter stepping +1/+2/-1/-2 with wraparound and a
//           synchronous load. Reaching all-ones is a winner event, reaching
//           zero a loser event; the first kind to collect WIN_LIMIT events
//           ends the game with a gameover pulse and a held result code.
// Ports   : clk          in  1  rising-edge clock
//           rst          in  1  synchronous reset, active-high
//           init         in  1  load count from initial_val (no events)
//           initial_val  in  N  load value
//           control      in  2  00 up+1, 01 up+2, 10 down-1, 11 down-2
//           winner       out 1  pulse: count became 2^N-1
//           loser        out 1  pulse: count became 0
//           count        out N  current count
//           gameover     out 1  pulse: a tally reached WIN_LIMIT
//           who          out 2  00 none, 01 loser side won, 10 winner side won
module main_counter
  import main_counter_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int WIN_LIMIT = WIN_LIMIT_DEF,
  parameter int T         = T_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic [N-1:0] initial_val,
  input  logic [1:0]   control,
  output logic         winner,
  output logic         loser,
  output logic [N-1:0] count,
  output logic         gameover,
  output logic [1:0]   who
);

  logic [N-1:0] count_q, count_d;
  logic         winner_q, winner_d;
  logic         loser_q, loser_d;
  logic         gameover_q, gameover_d;
  who_e         who_q, who_d;

  logic [N-1:0] nxt;
  ctrl_e        mode;
  logic         win_ev, lose_ev;
  logic         win_hit, lose_hit;
  logic         game_end;
  logic [T-1:0] win_cnt, lose_cnt;
  logic         unused_tally_cnt;

  assign mode = ctrl_e'(control);

  // N-bit arithmetic wraps modulo 2^N in both directions on its own.
  always_comb begin
    nxt = count_q;
    unique case (mode)
      UP1: nxt = count_q + N'(1);
      UP2: nxt = count_q + N'(2);
      DN1: nxt = count_q - N'(1);
      DN2: nxt = count_q - N'(2);
      default: nxt = count_q;
    endcase
  end

  // Events only exist on counting edges; rst and init suppress them.
  assign win_ev   = !rst && !init && (nxt == {N{1'b1}});
  assign lose_ev  = !rst && !init && (nxt == '0);
  assign game_end = (win_ev && win_hit) || (lose_ev && lose_hit);

  event_tally #(.T(T), .LIMIT(WIN_LIMIT)) u_win_tally (
    .clk      (clk),
    .rst      (rst),
    .clr      (game_end),
    .inc      (win_ev),
    .cnt      (win_cnt),
    .hit_next (win_hit)
  );

  event_tally #(.T(T), .LIMIT(WIN_LIMIT)) u_lose_tally (
    .clk      (clk),
    .rst      (rst),
    .clr      (game_end),
    .inc      (lose_ev),
    .cnt      (lose_cnt),
    .hit_next (lose_hit)
  );

  // Raw tally values are not needed at this level; the look-ahead flag suffices.
  assign unused_tally_cnt = ^{win_cnt, lose_cnt};

  always_comb begin
    count_d    = count_q;
    winner_d   = 1'b0;
    loser_d    = 1'b0;
    gameover_d = 1'b0;
    who_d      = who_q;
    if (init) begin
      count_d = initial_val;
    end else begin
      count_d    = nxt;
      winner_d   = win_ev;
      loser_d    = lose_ev;
      gameover_d = game_end;
      // who persists across later games until the next game end or rst.
      if (game_end) begin
        who_d = win_ev ? WIN : LOSE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      gameover_q <= 1'b0;
      who_q      <= NONE;
    end else begin
      count_q    <= count_d;
      winner_q   <= winner_d;
      loser_q    <= loser_d;
      gameover_q <= gameover_d;
      who_q      <= who_d;
    end
  end

  assign count    = count_q;
  assign winner   = winner_q;
  assign loser    = loser_q;
  assign gameover = gameover_q;
  assign who      = who_q;

endmodule

// File: tb/tb_main_counter.sv
// tb/tb_main_counter.sv - scoreboard bench for main_counter against a game-rule model
module tb_main_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic [3:0] initial_val = 4'd0;
  logic [1:0] control = 2'b00;
  logic       winner, loser, gameover;
  logic [3:0] count;
  logic [1:0] who;

  main_counter dut (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .initial_val (initial_val),
    .control     (control),
    .winner      (winner),
    .loser       (loser),
    .count       (count),
    .gameover    (gameover),
    .who         (who)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    bit w;
    bit l;
    bit g;
    int who;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int n_gameover = 0;

  // Game-rule model state, plain integers.
  int m_count = 0;
  int m_wt = 0;
  int m_lt = 0;
  int m_who = 0;

  function automatic int delta_of(input logic [1:0] ctl);
    case (ctl)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return -1;
      default: return -2;
    endcase
  endfunction

  // Drive one cycle's inputs (at the falling edge) and queue the outputs the
  // following rising edge must produce.
  task automatic apply(input bit r, input bit ld, input int val, input logic [1:0] ctl);
    exp_t e;
    int nxt;
    rst = r;
    init = ld;
    initial_val = 4'(val);
    control = ctl;
    e.w = 0; e.l = 0; e.g = 0;
    if (r) begin
      m_count = 0; m_wt = 0; m_lt = 0; m_who = 0;
    end else if (ld) begin
      m_count = val;
    end else begin
      nxt = (((m_count + delta_of(ctl)) % 16) + 16) % 16;
      m_count = nxt;
      e.w = (nxt == 15);
      e.l = (nxt == 0);
      if (e.w) begin
        if (m_wt == 14) begin
          e.g = 1; m_who = 2; m_wt = 0; m_lt = 0;
        end else begin
          m_wt++;
        end
      end
      if (e.l) begin
        if (m_lt == 14) begin
          e.g = 1; m_who = 1; m_wt = 0; m_lt = 0;
        end else begin
          m_lt++;
        end
      end
    end
    e.c = m_count;
    e.who = m_who;
    if (e.g) n_gameover++;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the DUT presents a result every cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (count !== 4'(e.c) || winner !== e.w || loser !== e.l ||
            gameover !== e.g || who !== 2'(e.who)) begin
          miscompares++;
          $display("FAIL vec%0d: got count=%0d win=%b lose=%b go=%b who=%b, want count=%0d win=%b lose=%b go=%b who=%b",
                   vectors, count, winner, loser, gameover, who,
                   e.c, e.w, e.l, e.g, 2'(e.who));
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset.
    apply(1, 0, 0, 2'b00);
    apply(1, 0, 0, 2'b00);
    // init held: count pinned, no events.
    for (int i = 0; i < 20; i++) apply(0, 1, 6, 2'b10);
    // 13 up+1 -> 14, 15(W), 0(L), 1.
    apply(0, 1, 13, 2'b00);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 2'b00);
    // 14 up+2 -> 0(L), 2; 1 down-2 -> 15(W), 13.
    apply(0, 1, 14, 2'b01);
    for (int i = 0; i < 2; i++) apply(0, 0, 0, 2'b01);
    apply(0, 1, 1, 2'b11);
    for (int i = 0; i < 2; i++) apply(0, 0, 0, 2'b11);
    // Full game from a clean reset: winner side reaches the limit first.
    apply(1, 0, 0, 2'b00);
    apply(0, 1, 14, 2'b00);
    for (int i = 0; i < 16 * 15 + 20; i++) apply(0, 0, 0, 2'b00);
    // A few events, then reset mid-game, then a complete second game.
    for (int i = 0; i < 40; i++) apply(0, 0, 0, 2'b00);
    apply(1, 0, 0, 2'b00);
    for (int i = 0; i < 16 * 15 + 20; i++) apply(0, 0, 0, 2'b10);
    // init mid-game keeps tallies.
    for (int i = 0; i < 100; i++) apply(0, (i % 17) == 3, 5, 2'b11);
    // Randomized mix.
    for (int i = 0; i < 4000; i++) begin
      apply(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    vectors++;
    if (n_gameover < 2) begin
      miscompares++;
      $display("FAIL coverage_gameover: got %0d games ended, want at least 2", n_gameover);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
